switch_traffic_gen: RTL and testbench
=====================================

Name: switch_traffic_gen

Overview:
Synthesizable stimulus source that drives the input side of the 4-port byte switch, i.e. its valid_in, addr_in and data_in buses. After a start pulse it issues a programmed number of beats. Destinations come from an LFSR. Per cycle the block guarantees one-to-one routing: no two ports target the same destination. Data bytes carry a port tag and a sequence number, so the output side can be checked beat by beat.

Parameters:
NUM_PORTS, 4, number of switch ports (lane count; fixed at 4 for this revision)
LANE_W, 8, width of each data/addr lane in bits
SEED, 16'hACE1, LFSR reset value (must be nonzero)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a run when idle
pkt_count  in  16  total beats to issue across all ports; sampled at start
gap  in  4  idle cycles inserted after each issuing cycle; sampled at start
port_en  in  4  enabled source ports; sampled at start
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse at the end of a run
sent_count  out  16  beats issued in the current/last run
valid_in  out  4  per-port beat valid, to switch
addr_in  out  32  per-port destination, byte lane p = bits [8p+7:8p], to switch
data_in  out  32  per-port data byte, same lane mapping, to switch

Behaviour:
- Reset (async): FSM=IDLE; LFSR=SEED; busy, done, valid_in, addr_in, data_in, sent_count = 0; all per-port seq counters = 0.
- All outputs are registered. A start in cycle N gives the first valid beat in cycle N+1.
- FSM states:
  - IDLE: start=1 latches pkt_count, gap and port_en, and clears sent_count and the seq counters. Go to DONE if pkt_count==0 or port_en==0; otherwise go to RUN.
  - RUN: issue one beat set this cycle. Go to DONE if the remaining count reaches 0. Else go to GAP if gap>0. Else stay in RUN.
  - GAP: count gap cycles with all valid_in=0, then return to RUN.
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- start is ignored while busy.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances once per RUN cycle only.
- Candidate destination for port p = LFSR[2p+1:2p].
- Arbitration in RUN:
  - Visit ports in order rr, rr+1, ... mod 4.
  - An enabled port is granted if its candidate destination is not already claimed this cycle and remaining>0. Each grant decrements remaining.
  - A port that loses arbitration drives valid=0 that cycle. Its beat is not lost; it is retried later with a new destination.
  - rr increments mod 4 on every RUN cycle.
- Granted lane p drives:
  - valid_in[p]=1
  - addr_in lane = zero-extended destination (0..3)
  - data_in lane = {p[1:0], seq_p[5:0]}
  - seq_p increments after the grant and wraps 63 -> 0.
- Non-granted lanes drive valid=0, addr=0, data=0 (never X or Z).
- sent_count increments by the number of grants each cycle. It saturates at pkt_count and holds after done until the next start.
- Invariants:
  - At most one valid lane per destination per cycle.
  - At most pkt_count total grants per run.
- Final cycle: if remaining < number of eligible ports, only the first `remaining` grants in rr order are issued.
- reset asserted mid-run: outputs go to 0 immediately (asynchronous); no done pulse.

Test Plan:
- Reset mid-RUN (pkt_count=100) -> valid_in/addr_in/data_in = 0 in the same cycle, busy=0, no done pulse; next run starts from seq=0, LFSR=SEED.
- port_en=4'b0001, pkt_count=5, gap=0 -> lane 0 valid for 5 consecutive cycles starting cycle after start; data_in[7:0]=8'h00..8'h04; done in cycle 6; sent_count=5.
- port_en=4'b0010, pkt_count=3, gap=2 -> valid pattern 1,0,0,1,0,0,1; data lane 1 = 8'h40,8'h41,8'h42; done follows last beat.
- port_en=4'b1111, pkt_count=1000, gap=0 -> every cycle the addr_in destinations of valid lanes are distinct; sent_count reaches 1000 exactly; seq wraps 63 -> 0 with the tag preserved (e.g. 8'hFF -> 8'hC0 on lane 3).
- pkt_count=0 or port_en=0 at start -> no valid beats, done pulses one cycle after start, sent_count=0; a start during busy has no effect.
- port_en=4'b1111, pkt_count=6 -> total grants exactly 6; the last cycle is truncated in rr order; valid_in=0 after done.

Source files
------------

// File: rtl/switch_traffic_gen.sv
// Stimulus source for the 4-port byte switch: issues a programmed number of
// beats with LFSR destinations, one-to-one routed per cycle, tagged data bytes.
module switch_traffic_gen #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned LANE_W    = 8,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [15:0]                 pkt_count,
  input  logic [3:0]                  gap,
  input  logic [NUM_PORTS-1:0]        port_en,
  output logic                        busy,
  output logic                        done,
  output logic [15:0]                 sent_count,
  output logic [NUM_PORTS-1:0]        valid_in,
  output logic [NUM_PORTS*LANE_W-1:0] addr_in,
  output logic [NUM_PORTS*LANE_W-1:0] data_in
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state, state_nx;
  logic [15:0] lfsr;
  logic [1:0]  rr;
  logic [15:0] remaining;
  logic [3:0]  gap_r, gap_cnt, gap_cnt_nx;
  logic [NUM_PORTS-1:0] en_r;
  logic [5:0]  seq [NUM_PORTS];

  logic        issue, start_acc;
  logic [NUM_PORTS-1:0] en_c, grant, claimed;
  logic [15:0] rem_c, rem_v;
  logic [2:0]  ngrant;
  logic [1:0]  p_c, d_c;
  logic [5:0]  seq_c;
  logic [NUM_PORTS*LANE_W-1:0] addr_nx, data_nx;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next state; "issue" marks an edge that loads a beat set into the output lanes.
  always_comb begin
    state_nx   = state;
    issue      = 1'b0;
    start_acc  = 1'b0;
    gap_cnt_nx = gap_cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          if (pkt_count == 16'd0 || port_en == '0) begin
            state_nx = S_DONE;
          end else begin
            state_nx = S_RUN;
            issue    = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (remaining == 16'd0) begin
          state_nx = S_DONE;
        end else if (gap_r != 4'd0) begin
          state_nx   = S_GAP;
          gap_cnt_nx = gap_r;
        end else begin
          issue = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt <= 4'd1) begin
          state_nx = S_RUN;
          issue    = 1'b1;
        end else begin
          gap_cnt_nx = gap_cnt - 4'd1;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // At start the run parameters are not latched yet, so arbitrate on the raw inputs.
  assign en_c  = (state == S_IDLE) ? port_en : en_r;
  assign rem_c = (state == S_IDLE) ? pkt_count : remaining;

  // Round-robin arbitration: first claim on a destination wins, bounded by remaining.
  always_comb begin
    claimed = '0;
    grant   = '0;
    rem_v   = rem_c;
    ngrant  = 3'd0;
    addr_nx = '0;
    data_nx = '0;
    p_c     = 2'd0;
    d_c     = 2'd0;
    seq_c   = 6'd0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      p_c   = rr + 2'(i);
      d_c   = lfsr[{p_c, 1'b0} +: 2];
      seq_c = (state == S_IDLE) ? 6'd0 : seq[p_c];
      if (en_c[p_c] && !claimed[d_c] && rem_v != 16'd0) begin
        grant[p_c]   = 1'b1;
        claimed[d_c] = 1'b1;
        rem_v        = rem_v - 16'd1;
        ngrant       = ngrant + 3'd1;
        addr_nx[LANE_W*p_c +: LANE_W] = LANE_W'(d_c);
        data_nx[LANE_W*p_c +: LANE_W] = LANE_W'({p_c, seq_c});
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      sent_count <= 16'd0;
      valid_in   <= '0;
      addr_in    <= '0;
      data_in    <= '0;
      lfsr       <= SEED;
      rr         <= 2'd0;
      remaining  <= 16'd0;
      gap_r      <= 4'd0;
      gap_cnt    <= 4'd0;
      en_r       <= '0;
      for (int i = 0; i < NUM_PORTS; i++) seq[i] <= 6'd0;
    end else begin
      busy     <= (state_nx == S_RUN) || (state_nx == S_GAP);
      done     <= (state_nx == S_DONE);
      gap_cnt  <= gap_cnt_nx;
      valid_in <= issue ? grant : '0;
      addr_in  <= issue ? addr_nx : '0;
      data_in  <= issue ? data_nx : '0;
      if (start_acc) begin
        gap_r      <= gap;
        en_r       <= port_en;
        remaining  <= pkt_count;
        sent_count <= 16'd0;
      end
      if (issue) begin
        lfsr       <= {lfsr[14:0], lfsr_fb};
        rr         <= rr + 2'd1;
        remaining  <= rem_v;
        sent_count <= (start_acc ? 16'd0 : sent_count) + 16'(ngrant);
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (start_acc)
          seq[i] <= (issue && grant[i]) ? 6'd1 : 6'd0;
        else if (issue && grant[i])
          seq[i] <= seq[i] + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_switch_traffic_gen.sv
// Bench for switch_traffic_gen: a reference model pushes per-cycle expected
// outputs to a queue at start; each cycle pops and compares against the DUT.
module tb_switch_traffic_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] pkt_count;
  logic [3:0]  gap;
  logic [3:0]  port_en;
  logic        busy, done;
  logic [15:0] sent_count;
  logic [3:0]  valid_in;
  logic [31:0] addr_in, data_in;

  switch_traffic_gen dut (
    .clk(clk), .reset(reset), .start(start), .pkt_count(pkt_count), .gap(gap),
    .port_en(port_en), .busy(busy), .done(done), .sent_count(sent_count),
    .valid_in(valid_in), .addr_in(addr_in), .data_in(data_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  v;
    logic [31:0] a;
    logic [31:0] d;
    logic        busy;
    logic        done;
    logic [15:0] sent;
  } exp_t;

  typedef struct {
    logic [15:0] pkt;
    logic [3:0]  gap;
    logic [3:0]  en;
    logic [15:0] exp_sent;
  } vec_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;

  logic [15:0] m_lfsr;
  int          m_rr;
  logic [5:0]  m_seq [4];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    else n_pass++;
  endtask

  function automatic exp_t blank(input logic b, input logic dn, input int s);
    exp_t e;
    e.v = '0; e.a = '0; e.d = '0; e.busy = b; e.done = dn; e.sent = 16'(s);
    return e;
  endfunction

  // Reference model of one run, from the cycle after start through one idle cycle.
  task automatic model_run(input int pkt, input int g, input logic [3:0] en);
    exp_t e;
    int rem, sent, p, dst;
    logic [3:0] taken;
    if (pkt == 0 || en == 4'b0) begin
      q.push_back(blank(1'b0, 1'b1, 0));
      q.push_back(blank(1'b0, 1'b0, 0));
      return;
    end
    rem = pkt; sent = 0;
    for (int k = 0; k < 4; k++) m_seq[k] = 6'd0;
    forever begin
      e = blank(1'b1, 1'b0, 0);
      taken = '0;
      for (int k = 0; k < 4; k++) begin
        p   = (m_rr + k) % 4;
        dst = int'((m_lfsr >> (2 * p)) & 16'd3);
        if (en[p] && !taken[dst] && rem > 0) begin
          e.v[p] = 1'b1;
          e.a[8*p +: 8] = 8'(dst);
          e.d[8*p +: 8] = {2'(p), m_seq[p]};
          m_seq[p] = m_seq[p] + 6'd1;
          taken[dst] = 1'b1;
          rem--; sent++;
        end
      end
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      m_rr   = (m_rr + 1) % 4;
      e.sent = 16'(sent);
      q.push_back(e);
      if (rem == 0) break;
      repeat (g) q.push_back(blank(1'b1, 1'b0, sent));
    end
    q.push_back(blank(1'b0, 1'b1, sent));
    q.push_back(blank(1'b0, 1'b0, sent));
  endtask

  task automatic cmp_cycle(input exp_t e);
    logic [3:0] mask;
    int nv;
    chk("valid_in", 32'(valid_in), 32'(e.v));
    chk("addr_in", addr_in, e.a);
    chk("data_in", data_in, e.d);
    chk("busy", 32'(busy), 32'(e.busy));
    chk("done", 32'(done), 32'(e.done));
    chk("sent_count", 32'(sent_count), 32'(e.sent));
    mask = '0; nv = 0;
    for (int p = 0; p < 4; p++) begin
      if (valid_in[p] === 1'b1) begin
        nv++;
        mask[addr_in[8*p +: 2]] = 1'b1;
      end
    end
    chk("unique_dest", 32'($countones(mask) == nv), 32'd1);
  endtask

  // Start a run and compare cycle by cycle; abort_at >= 0 stops early leaving the queue.
  task automatic run_case(input vec_t v, input bit poke_busy, input int abort_at);
    exp_t e;
    int idx;
    @(negedge clk);
    pkt_count = v.pkt; gap = v.gap; port_en = v.en; start = 1'b1;
    model_run(int'(v.pkt), int'(v.gap), v.en);
    idx = 0;
    while (q.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      pkt_count = 16'($urandom_range(0, 65535));
      port_en   = 4'($urandom_range(0, 15));
      gap       = 4'($urandom_range(0, 15));
      if (idx == abort_at) return;
      e = q.pop_front();
      cmp_cycle(e);
      if (poke_busy && idx == 2) begin
        pkt_count = 16'd0; port_en = 4'b1111; start = 1'b1;
      end
      idx++;
    end
    chk("final_sent", 32'(sent_count), 32'(v.exp_sent));
  endtask

  vec_t vecs[7];
  vec_t v;

  initial begin
    vecs[0] = '{16'd5,    4'd0, 4'b0001, 16'd5};
    vecs[1] = '{16'd3,    4'd2, 4'b0010, 16'd3};
    vecs[2] = '{16'd1000, 4'd0, 4'b1111, 16'd1000};
    vecs[3] = '{16'd0,    4'd0, 4'b1111, 16'd0};
    vecs[4] = '{16'd7,    4'd3, 4'b0000, 16'd0};
    vecs[5] = '{16'd6,    4'd0, 4'b1111, 16'd6};
    vecs[6] = '{16'd20,   4'd1, 4'b0101, 16'd20};

    reset = 1'b1; start = 1'b0; pkt_count = '0; gap = '0; port_en = '0;
    m_lfsr = 16'hACE1; m_rr = 0;
    for (int k = 0; k < 4; k++) m_seq[k] = 6'd0;
    repeat (2) @(negedge clk);
    cmp_cycle(blank(1'b0, 1'b0, 0));
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_case(vecs[i], i == 6, -1);

    // Asynchronous reset in the middle of a long run.
    v = '{16'd100, 4'd0, 4'b1111, 16'd0};
    run_case(v, 1'b0, 8);
    q.delete();
    #2 reset = 1'b1;
    #1 cmp_cycle(blank(1'b0, 1'b0, 0));
    repeat (2) begin
      @(negedge clk);
      chk("no_done_in_reset", 32'(done), 32'd0);
    end
    reset = 1'b0;
    m_lfsr = 16'hACE1; m_rr = 0;
    @(negedge clk);
    chk("idle_after_reset", 32'(busy | done), 32'd0);
    v = '{16'd5, 4'd0, 4'b0001, 16'd5};
    run_case(v, 1'b0, -1);
    v = '{16'd9, 4'd1, 4'b1011, 16'd9};
    run_case(v, 1'b0, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
